// File: rtl/skid_reg_32_pkg.sv
// Shared definitions for the skid_reg_32 slice: the controller state encoding
// and the default data path width.
package skid_reg_32_pkg;

  localparam int unsigned DefaultWidth = 32;

  // EMPTY: no beats, FULL: main valid, SKID: main and skid valid.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2
  } state_e;

endpackage

// File: rtl/skid_ctrl.sv
// Control FSM for the two-entry skid register.
// Ports:
//   clk, clr_n            clock, asynchronous active-low reset
//   flush                 synchronous drop-all request
//   in_valid, out_ready   upstream valid / downstream ready
//   in_ready, out_valid   handshake outputs, decoded from registered state only
//   occupancy             held beats (0..2)
//   load_main, load_skid  datapath register enables
//   sel_skid              main loads from skid instead of in_data
module skid_ctrl
  import skid_reg_32_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic       flush,
  input  logic       in_valid,
  input  logic       out_ready,
  output logic       in_ready,
  output logic       out_valid,
  output logic [1:0] occupancy,
  output logic       load_main,
  output logic       load_skid,
  output logic       sel_skid
);

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake outputs come from state_q alone so in_ready never sees out_ready.
  always_comb begin
    in_ready  = (state_q != StSkid);
    out_valid = (state_q != StEmpty);
    occupancy = 2'd0;
    unique case (state_q)
      StFull:  occupancy = 2'd1;
      StSkid:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    sel_skid  = 1'b0;
    if (flush) begin
      // Storage is left untouched; any beat handshaken this cycle is dropped.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_valid) begin
            load_main = 1'b1;
            state_d   = StFull;
          end
        end
        StFull: begin
          if (in_valid && out_ready) begin
            load_main = 1'b1;
          end else if (out_ready) begin
            state_d = StEmpty;
          end else if (in_valid) begin
            load_skid = 1'b1;
            state_d   = StSkid;
          end
        end
        StSkid: begin
          if (out_ready) begin
            load_main = 1'b1;
            sel_skid  = 1'b1;
            state_d   = StFull;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

endmodule

// File: rtl/skid_reg_32.sv
// Two-entry skid register: fully registered valid/ready stage that sustains one
// beat per cycle without a combinational path from out_ready to in_ready.
// Ports:
//   clk, clr_n                    clock, asynchronous active-low reset
//   flush                         synchronous drop-all (storage contents kept)
//   in_valid, in_ready, in_data   upstream handshake and payload
//   out_valid, out_ready, out_data downstream handshake and head payload
//   occupancy                     held beats (0..2)
module skid_reg_32
  import skid_reg_32_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic             load_main, load_skid, sel_skid;
  logic [WIDTH-1:0] main_q, skid_q;

  skid_ctrl u_ctrl (
    .clk       (clk),
    .clr_n     (clr_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .occupancy (occupancy),
    .load_main (load_main),
    .load_skid (load_skid),
    .sel_skid  (sel_skid)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      main_q <= '0;
    end else if (load_main) begin
      main_q <= sel_skid ? skid_q : in_data;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      skid_q <= '0;
    end else if (load_skid) begin
      skid_q <= in_data;
    end
  end

  // Main keeps its last value when empty; consumers qualify with out_valid.
  assign out_data = main_q;

endmodule

// File: tb/tb_skid_reg_32.sv
module tb_skid_reg_32;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  skid_reg_32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        e_valid;
    logic        e_ready;
    logic [1:0]  e_occ;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  // Reference model: ordered list of held beats plus the last head value.
  logic [31:0] q[$];
  logic [31:0] last_head;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic r, input logic [1:0] o,
                         input logic [31:0] dd);
    chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, " in_ready"}, {31'd0, in_ready}, {31'd0, r});
    chk({tag, " occupancy"}, {30'd0, occupancy}, {30'd0, o});
    chk({tag, " out_data"}, out_data, dd);
  endtask

  // Apply inputs at negedge, sample 1 time unit after the following posedge.
  task automatic step(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
    @(negedge clk);
    flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic fl, input logic iv, input logic [31:0] d, input logic ordy,
                     input logic v, input logic r, input logic [1:0] o, input logic [31:0] dd);
    vec_t t;
    t.fl = fl; t.iv = iv; t.d = d; t.ordy = ordy;
    t.e_valid = v; t.e_ready = r; t.e_occ = o; t.e_data = dd;
    vecs.push_back(t);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    #2;
    @(negedge clk);
    clr_n = 1'b1;
    q.delete();
    last_head = '0;
  endtask

  initial begin
    clr_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    q.delete();
    last_head = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 1'b1, 2'd0, 32'h0);
    @(negedge clk);
    clr_n = 1'b1;

    //   fl  iv  data   ordy  valid ready occ data
    add(0, 1, 32'h01, 1, 1, 1, 2'd1, 32'h01); // streaming
    add(0, 1, 32'h02, 1, 1, 1, 2'd1, 32'h02);
    add(0, 1, 32'h03, 1, 1, 1, 2'd1, 32'h03);
    add(0, 0, 32'h99, 1, 0, 1, 2'd0, 32'h03); // drain keeps last value
    add(0, 1, 32'h10, 0, 1, 1, 2'd1, 32'h10); // backpressure
    add(0, 1, 32'h11, 0, 1, 0, 2'd2, 32'h10);
    add(0, 1, 32'h12, 0, 1, 0, 2'd2, 32'h10); // 0x12 not accepted
    add(0, 1, 32'h12, 1, 1, 1, 2'd1, 32'h11); // still not accepted, skid -> main
    add(0, 1, 32'h12, 1, 1, 1, 2'd1, 32'h12);
    add(0, 0, 32'h00, 1, 0, 1, 2'd0, 32'h12);
    add(0, 1, 32'h20, 0, 1, 1, 2'd1, 32'h20); // simultaneous in/out
    add(0, 1, 32'h21, 1, 1, 1, 2'd1, 32'h21);
    add(0, 0, 32'h00, 1, 0, 1, 2'd0, 32'h21);
    add(0, 1, 32'h30, 0, 1, 1, 2'd1, 32'h30); // flush from SKID
    add(0, 1, 32'h31, 0, 1, 0, 2'd2, 32'h30);
    add(1, 1, 32'h32, 0, 0, 1, 2'd0, 32'h30);
    add(0, 0, 32'h00, 1, 0, 1, 2'd0, 32'h30);
    add(0, 1, 32'h40, 0, 1, 1, 2'd1, 32'h40); // flush from FULL with handshake
    add(1, 1, 32'h41, 1, 0, 1, 2'd0, 32'h40);
    add(0, 0, 32'h00, 1, 0, 1, 2'd0, 32'h40);
    add(1, 1, 32'h50, 1, 0, 1, 2'd0, 32'h40); // flush from EMPTY
    add(0, 0, 32'h00, 0, 0, 1, 2'd0, 32'h40);

    foreach (vecs[i]) begin
      step(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_ready, vecs[i].e_occ,
              vecs[i].e_data);
    end

    // Asynchronous reset while in SKID holding 0xA, 0xB.
    step(0, 1, 32'hA, 0);
    step(0, 1, 32'hB, 0);
    chk_all("pre-areset", 1'b1, 1'b0, 2'd2, 32'hA);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    clr_n = 1'b0;
    #1;
    chk_all("areset", 1'b0, 1'b1, 2'd0, 32'h0);
    @(negedge clk);
    clr_n = 1'b1;
    step(0, 1, 32'hC, 0);
    chk_all("post-areset", 1'b1, 1'b1, 2'd1, 32'hC);
    step(0, 0, 32'h0, 1);
    chk_all("post-areset drain", 1'b0, 1'b1, 2'd0, 32'hC);

    // Randomised run against the queue model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      logic        fl, iv, ordy, rdy_m;
      logic [31:0] d;
      fl   = ($urandom_range(0, 19) == 0);
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      d    = $urandom;
      rdy_m = (q.size() < 2);
      step(fl, iv, d, ordy);
      if (fl) begin
        q.delete();
      end else begin
        if (q.size() > 0 && ordy) void'(q.pop_front());
        if (iv && rdy_m) q.push_back(d);
      end
      if (q.size() > 0) last_head = q[0];
      chk_all($sformatf("rand%0d", i), q.size() > 0, q.size() < 2, 2'(q.size()), last_head);
      if (i == 1000) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/skid_reg_32.md
SKID_REG_32 -- requirements
Module: skid_reg_32

Interface
REQ-001 Parameter: WIDTH, default 32, data path width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: clr_n  input  1  asynchronous active-low reset.
REQ-004 Port: flush  input  1  synchronous drop-all request, active high.
REQ-005 Port: in_valid  input  1  upstream beat present on in_data.
REQ-006 Port: in_ready  output  1  block accepts a beat this cycle.
REQ-007 Port: in_data  input  WIDTH  upstream beat payload.
REQ-008 Port: out_valid  output  1  out_data holds a valid beat.
REQ-009 Port: out_ready  input  1  downstream consumes the beat this cycle.
REQ-010 Port: out_data  output  WIDTH  head beat payload.
REQ-011 Port: occupancy  output  2  number of held beats (0..2).

Function
REQ-012 Beat transfer on input SHALL occur iff in_valid & in_ready at posedge clk; on output iff out_valid & out_ready.
REQ-013 Storage SHALL be two WIDTH-bit registers: main (drives out_data) and skid.
REQ-014 FSM states SHALL be EMPTY (0 beats), FULL (main valid), SKID (main and skid valid).
REQ-015 in_ready SHALL equal (state != SKID) and depend only on registered state, never combinationally on out_ready.
REQ-016 out_valid SHALL equal (state != EMPTY); occupancy SHALL be 0/1/2 for EMPTY/FULL/SKID.
REQ-017 EMPTY: in_valid -> main <= in_data, go FULL; else hold.
REQ-018 FULL: in_valid & out_ready -> main <= in_data, stay FULL; !in_valid & out_ready -> EMPTY; in_valid & !out_ready -> skid <= in_data, go SKID; neither -> hold.
REQ-019 SKID: out_ready -> main <= skid, go FULL; else hold; no input accepted.
REQ-020 Latency SHALL be one cycle from input transfer to out_valid; sustained throughput one beat per cycle with out_ready held high.
REQ-021 Beat order SHALL be strictly preserved; no beat SHALL be duplicated or lost except by flush or reset.
REQ-022 flush SHALL take priority over all transfers: next state EMPTY, any beat accepted in the flush cycle discarded, main/skid contents unchanged.
REQ-023 out_data while EMPTY SHALL equal the last main value (0 after reset); consumers SHALL qualify it with out_valid.
REQ-024 main and skid SHALL load only on the transfers listed above; otherwise hold.

Reset
REQ-025 clr_n low SHALL asynchronously force state EMPTY and main = skid = 0, regardless of clk.
REQ-026 During and after reset: out_valid = 0, occupancy = 0, in_ready = 1, out_data = 0.
REQ-027 Reset asserted mid-operation SHALL discard all held beats; first transfer after deassertion SHALL behave as from EMPTY.
REQ-028 Reset deassertion SHALL take effect at the first posedge clk with clr_n high.

Structure
REQ-029 Shared package SHALL hold the state encoding (EMPTY=2'd0, FULL=2'd1, SKID=2'd2) and the default WIDTH constant.
REQ-030 One sub-module, skid_ctrl, SHALL contain the FSM and produce in_ready, out_valid, occupancy, load_main, load_skid, sel_skid; top level holds datapath registers only.
REQ-031 Unused state encoding 2'd3 SHALL return to EMPTY on next clock.

Verification
REQ-032 Reset: clr_n low mid-SKID with main=0xA, skid=0xB -> immediately out_valid=0, occupancy=0, in_ready=1, out_data=0.
REQ-033 Streaming: out_ready=1, in_valid=1 with 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 one cycle later each, occupancy stays 1.
REQ-034 Backpressure: send 0x10, 0x11 with out_ready=0 -> occupancy=2, in_ready=0; 0x12 held at input not accepted; raise out_ready -> outputs 0x10, 0x11, 0x12 in order, no loss.
REQ-035 Simultaneous: FULL with 0x20, in_valid=1 (0x21) and out_ready=1 same cycle -> 0x20 consumed, out_data=0x21 next cycle, occupancy=1.
REQ-036 Flush: SKID holding 0x30,0x31, flush=1 with in_valid=1 (0x32) -> next cycle EMPTY, out_valid=0, 0x32 never appears at output.
REQ-037 Drain: FULL, in_valid=0, out_ready=1 -> EMPTY next cycle, out_valid=0, out_data retains last value.
